// File: rtl/mux_n_1_reg.sv
// Registered N:1 multiplexer with a two-entry (output + skid) valid/ready buffer.
// Optional macro MUX_SEL_CHECK_EN: out-of-range select stores zero and raises sticky sel_err.
module mux_n_1_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] oreg_q, sreg_q, word;
    logic             in_fire, out_fire;
    logic             load_oreg_word, load_oreg_skid, load_sreg;

    // Ready/valid decode from state only, so no out_ready -> in_ready path.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = oreg_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
`ifdef MUX_SEL_CHECK_EN
        word = '0;
`else
        word = in_data[WIDTH-1:0];
`endif
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(sel) == k) begin
                word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        load_oreg_word = 1'b0;
        load_oreg_skid = 1'b0;
        load_sreg      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_oreg_word = 1'b1;
                    state_d        = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_oreg_word = 1'b1;
                end else if (in_fire) begin
                    load_sreg = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_oreg_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            oreg_q  <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_oreg_word) begin
                oreg_q <= word;
            end else if (load_oreg_skid) begin
                oreg_q <= sreg_q;
            end
            if (load_sreg) begin
                sreg_q <= word;
            end
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic sel_oor;
    logic sel_err_q;

    assign sel_oor = (32'(sel) >= NUM_IN);
    assign sel_err = sel_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (in_fire && sel_oor) begin
            sel_err_q <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Bench for mux_n_1_reg: queue-based reference model checked every cycle, plus directed literal checks.
module tb_mux_n_1_reg;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = '0;
    logic [2:0]   sel = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sel_err;

    logic [95:0]  in3_data = '0;
    logic [1:0]   sel3 = '0;
    logic         in3_valid = 1'b0;
    logic         in3_ready;
    logic [31:0]  out3_data;
    logic         out3_valid;
    logic         sel3_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    bit          m_err = 1'b0;
    bit          live = 1'b0;

    always #5 clk = ~clk;

    // SEL_W=3 lets sel values 4..7 exercise the out-of-range path.
    mux_n_1_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(3)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    mux_n_1_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in3_data), .sel(sel3), .in_valid(in3_valid),
        .in_ready(in3_ready), .out_data(out3_data), .out_valid(out3_valid),
        .out_ready(1'b1), .sel_err(sel3_err)
    );

    function automatic logic [31:0] mword(input logic [127:0] d, input logic [2:0] s);
        if (s < 3'd4) return d[s*32 +: 32];
`ifdef MUX_SEL_CHECK_EN
        return 32'h0;
`else
        return d[31:0];
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Reference model: a FIFO of at most two words.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_err = 1'b0;
                live  = 1'b1;
            end else begin
                bit ifire, ofire;
                ifire = in_valid && (q.size() < 2);
                ofire = out_ready && (q.size() > 0);
                if (ofire) void'(q.pop_front());
                if (ifire) begin
                    q.push_back(mword(in_data, sel));
`ifdef MUX_SEL_CHECK_EN
                    if (sel >= 3'd4) m_err = 1'b1;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            chk("sel_err", {31'b0, sel_err}, {31'b0, m_err});
            if (q.size() > 0) chk("out_data", out_data, q[0]);
        end
    end

    initial begin
        logic [31:0] e;
        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_sel_err", {31'b0, sel_err}, 32'd0);
        in_data = {32'h33, 32'h22, 32'h11, 32'h00};

        // Pass-through
        out_ready = 1'b1; in_valid = 1'b1; sel = 3'd2;
        cyc();
        in_valid = 1'b0;
        chk("pt_data", out_data, 32'h22);
        chk("pt_valid", {31'b0, out_valid}, 32'd1);
        cyc();
        chk("pt_empty", {31'b0, out_valid}, 32'd0);

        // Back-pressure
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
        cyc();
        sel = 3'd1;
        cyc();
        sel = 3'd2;
        chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
        cyc();
        chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_data", out_data, 32'h00);
        out_ready = 1'b1;
        cyc();
        chk("bp_second", out_data, 32'h11);
        cyc();
        in_valid = 1'b0;
        chk("bp_third", out_data, 32'h22);
        cyc();
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; sel = 3'(i % 4);
            chk("st_ready", {31'b0, in_ready}, 32'd1);
            cyc();
            chk("st_data", out_data, 32'h11 * (i % 4));
            chk("st_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        cyc();

        // Simultaneous in/out in ONE
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
        cyc();
        out_ready = 1'b1; sel = 3'd3;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("sim_data", out_data, 32'h33);
        chk("sim_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        cyc();

        // Mid-operation reset from FULL
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("mr_valid", {31'b0, out_valid}, 32'd0);
        chk("mr_ready", {31'b0, in_ready}, 32'd1);
        chk("mr_data", out_data, 32'h0);
        chk("mr_err", {31'b0, sel_err}, 32'd0);

        // Out-of-range select on the 4-input instance
        in_data = {32'h33, 32'h22, 32'h11, 32'hA5};
        out_ready = 1'b1; in_valid = 1'b1; sel = 3'd5;
        cyc();
        in_valid = 1'b0;
`ifdef MUX_SEL_CHECK_EN
        e = 32'h0;
`else
        e = 32'hA5;
`endif
        chk("oor4_data", out_data, e);
        cyc();

        // Out-of-range select on the 3-input instance
        in3_data = {32'h22, 32'h11, 32'hA0};
        in3_valid = 1'b1; sel3 = 2'd3;
        cyc();
        sel3 = 2'd1;
`ifdef MUX_SEL_CHECK_EN
        chk("oor3_data", out3_data, 32'h0);
        chk("oor3_err", {31'b0, sel3_err}, 32'd1);
`else
        chk("oor3_data", out3_data, 32'hA0);
        chk("oor3_err", {31'b0, sel3_err}, 32'd0);
`endif
        cyc();
        in3_valid = 1'b0;
        chk("oor3_next", out3_data, 32'h11);
`ifdef MUX_SEL_CHECK_EN
        chk("oor3_sticky", {31'b0, sel3_err}, 32'd1);
`else
        chk("oor3_sticky", {31'b0, sel3_err}, 32'd0);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("oor3_clr", {31'b0, sel3_err}, 32'd0);
        chk("oor3_rst_data", out3_data, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            sel       = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 65);
            rst       = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0; in_valid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
